arbitrated_fifos_lockstep: RTL and testbench
============================================

# arbitrated_fifos_lockstep

Parametrised successor to the two-copy arbitrated-FIFO proof harness. It instantiates NUM_COPIES independent `arbitrated_fifos` systems, each with its own `SimpleScoreboard` on fifo FIFO_SEL. It adds a lockstep comparator that checks every copy against copy 0 cycle by cycle. It latches the first divergence: a sticky flag, which copies diverged, and the cycle index. It is the top-level block for duplicate-system equivalence proofs and for simulation lockstep checks.

## Interface
- NUM_COPIES, 2, number of duplicated systems (≥1)
- NUM_REQS, `NUM_REQS, fifos per system
- WIDTH, `FIFO_DWIDTH, data width
- DEPTH, `FIFO_DEPTH, fifo depth
- QWID, `ARB_QWID, DWRR quantum width
- FIFO_SEL, 0, fifo index tracked by every scoreboard
- CNT_WID, 16, width of the cycle counters

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  scoreboard start, shared by all copies
- quantums  in  NUM_REQS*QWID  shared by all copies
- push  in  NUM_COPIES*NUM_REQS  copy c at [c*NUM_REQS +: NUM_REQS]
- reqs  in  NUM_COPIES*NUM_REQS  same packing as push
- flat_data_in  in  NUM_COPIES*NUM_REQS*WIDTH  copy c at [c*NUM_REQS*WIDTH +: NUM_REQS*WIDTH]
- check_en  in  1  comparator enable
- pop  out  NUM_COPIES*NUM_REQS  per-copy grants
- data_out  out  NUM_COPIES*WIDTH  per-copy output data
- prop_signal  out  NUM_COPIES  per-copy scoreboard property
- mismatch  out  1  sticky divergence flag
- mismatch_mask  out  NUM_COPIES  copies that diverged at the first mismatch; bit 0 is always 0
- mismatch_cycle  out  CNT_WID  cycle_cnt value in the detecting cycle
- cycle_cnt  out  CNT_WID  cycles spent in CHECK

## Operation
- Instantiate `arbitrated_fifos` with ABSTRACT=1 for each copy, plus one `SimpleScoreboard` per copy.
- Scoreboard c inputs:
  - push = push of copy c, bit FIFO_SEL
  - pop = pop of copy c, bit FIFO_SEL
  - data_in = copy c, fifo FIFO_SEL data
  - data_out = data_out of copy c
- Per-copy divergence, combinational, for c ≥ 1. diff[c] is set if any of:
  - pop_c ≠ pop_0
  - |pop_0 and data_out_c ≠ data_out_0 (data is compared only on grant cycles)
  - prop_signal_c ≠ prop_signal_0
- diff[0] is always 0.
- FSM states: IDLE, CHECK, FAIL.
  - rst → IDLE.
  - IDLE → CHECK when check_en = 1.
  - CHECK → FAIL when check_en = 1 and |diff. In that cycle, latch mismatch_mask ← diff and mismatch_cycle ← cycle_cnt.
  - CHECK → IDLE when check_en = 0. cycle_cnt holds.
  - FAIL is absorbing until rst. check_en is ignored.
- Comparison is performed in CHECK only. In the IDLE→CHECK entry cycle no comparison is made; checking starts the following cycle.
- cycle_cnt increments each CHECK cycle that has no divergence. It saturates at 2^CNT_WID−1 and does not wrap.
- mismatch = (state == FAIL).
- NUM_COPIES = 1: diff is always 0, so mismatch stays 0. The FSM and counter still run.

## Timing
- Reset values: mismatch = 0, mismatch_mask = 0, mismatch_cycle = 0, cycle_cnt = 0, state IDLE.
- pop, data_out and prop_signal follow the sub-block reset values.
- Arbiter and scoreboard latency are those of the sub-blocks; this block adds none to the data path.
- Detection latency is 1 cycle: divergence in cycle t gives mismatch = 1 from cycle t+1.
- If several copies diverge in the same cycle, all of their bits are set in mismatch_mask.
- If rst is asserted in any state, all comparator state clears on the next edge, and the sub-blocks reset at the same edge.
- check_en dropping in the same cycle as a diff: no latch, transition to IDLE.

## Structure
- Package `af_lockstep_pkg`:
  - state enum {IDLE, CHECK, FAIL}
  - default CNT_WID
  - packing helper functions for the copy slice offsets
- Sub-module `lockstep_cmp`, parametrised by NUM_COPIES, NUM_REQS, WIDTH and CNT_WID. It contains the diff logic, FSM, counter and latches.
- The top level contains only the generate loop over copies, the scoreboards and `lockstep_cmp`.

## Test plan
- Two copies, identical stimulus, check_en = 1, fifo 0 pushed 0x5 then 0xA, 200 cycles → mismatch = 0 throughout; prop_signal identical on both copies.
- Copy 1 fifo 0 pushed 0x6 where copy 0 is pushed 0x5, same cycle → mismatch = 1 one cycle after the differing grant. mismatch_mask = 2'b10; mismatch_cycle equals cycle_cnt at the grant.
- Same divergence with check_en = 0 → mismatch stays 0 and cycle_cnt does not advance. Raising check_en afterwards gives no detection for past events.
- CNT_WID = 4, 30 clean CHECK cycles → cycle_cnt = 4'hF, held.
- FAIL state, then rst pulsed for 1 cycle → next cycle mismatch = 0, mask = 0, cycle_cnt = 0, state IDLE.
- NUM_COPIES = 3, copy 2 reqs differs → mismatch_mask = 3'b100. Copies 1 and 2 diverging in the same cycle → 3'b110.

Source files
------------

// File: rtl/af_lockstep_pkg.sv
// Shared types, default sizes and slice-offset helpers for the lockstep harness.
package af_lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FAIL  = 2'd2
  } lk_state_e;

  localparam int DEF_NUM_REQS    = 2;
  localparam int DEF_FIFO_DWIDTH = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ARB_QWID    = 4;
  localparam int DEF_CNT_WID     = 16;

  // Low bit of copy c inside a per-request vector (push, reqs, pop).
  function automatic int req_lo(input int c, input int nreq);
    return c * nreq;
  endfunction

  // Low bit of copy c inside the flattened data-in bus.
  function automatic int dat_lo(input int c, input int nreq, input int w);
    return c * nreq * w;
  endfunction

endpackage

// File: rtl/SimpleScoreboard.sv
// Tracks the first word pushed after start through one FIFO and checks it pops
// out unchanged; prop_signal drops (sticky) on a corrupted word.
module SimpleScoreboard #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic             prop_signal
);

  localparam int CW = $clog2(DEPTH + 1) + 1;

  logic [CW-1:0]    occ_q, occ_d, ahead_q, ahead_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             armed_q, armed_d, track_q, track_d, bad_q, bad_d;

  always_comb begin
    occ_d   = occ_q + CW'(push) - CW'(pop);
    armed_d = armed_q | start;
    track_d = track_q;
    ahead_d = ahead_q;
    val_d   = val_q;
    bad_d   = bad_q;
    if (track_q) begin
      if (pop) begin
        if (ahead_q == '0) begin
          bad_d   = bad_q | (data_out != val_q);
          track_d = 1'b0;
        end else begin
          ahead_d = ahead_q - CW'(1);
        end
      end
    end else if ((armed_q || start) && push) begin
      // Words already queued ahead of the tracked one, minus any leaving now.
      track_d = 1'b1;
      armed_d = 1'b0;
      val_d   = data_in;
      ahead_d = occ_q - CW'(pop);
    end
    prop_signal = ~bad_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      ahead_q <= '0;
      val_q   <= '0;
      armed_q <= 1'b0;
      track_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      ahead_q <= ahead_d;
      val_q   <= val_d;
      armed_q <= armed_d;
      track_q <= track_d;
      bad_q   <= bad_d;
    end
  end

endmodule

// File: rtl/af_fifo.sv
// Generic synchronous FIFO with a combinational head; zero read latency.
// Pushes while full and pops while empty are dropped.
module af_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    head_dat = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/arbitrated_fifos.sv
// NUM_REQS FIFOs behind a deficit-weighted round-robin arbiter; the grant and
// head data are combinational from the current FIFO state (pop is the grant).
module arbitrated_fifos #(
  parameter int NUM_REQS = 2,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int QWID     = 4,
  parameter bit ABSTRACT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQS-1:0]       push,
  input  logic [NUM_REQS-1:0]       reqs,
  input  logic [NUM_REQS*WIDTH-1:0] data_in,
  input  logic [NUM_REQS*QWID-1:0]  quantums,
  output logic [NUM_REQS-1:0]       pop,
  output logic [WIDTH-1:0]          data_out
);

  localparam int IW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [WIDTH-1:0]    head [NUM_REQS];
  logic [NUM_REQS-1:0] empty, elig, grant;
  logic [IW-1:0]       cur_q, cur_d, sel;
  logic [QWID-1:0]     credit_q, credit_d, qnt;
  logic                found;
  int                  idx;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_fifo
    af_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .push_dat (data_in[i*WIDTH +: WIDTH]),
      .pop      (grant[i]),
      .head_dat (head[i]),
      .empty    (empty[i])
    );
  end

  // Stay on the current requester while it has credit, else move to the next
  // eligible one (the current one last) and reload its quantum.
  always_comb begin
    elig     = reqs & ~empty;
    grant    = '0;
    sel      = cur_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    found    = 1'b0;
    idx      = 0;
    qnt      = '0;
    if (elig[cur_q] && credit_q != '0) begin
      found    = 1'b1;
      credit_d = credit_q - QWID'(1);
    end else begin
      for (int k = 1; k <= NUM_REQS; k++) begin
        idx = (int'(cur_q) + k) % NUM_REQS;
        if (!found && elig[idx]) begin
          found    = 1'b1;
          sel      = IW'(idx);
          cur_d    = IW'(idx);
          qnt      = quantums[idx*QWID +: QWID];
          credit_d = (qnt == '0) ? '0 : qnt - QWID'(1);
        end
      end
    end
    if (found) grant[sel] = 1'b1;
    pop      = grant;
    data_out = (ABSTRACT && !found) ? '0 : head[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q    <= '0;
      credit_q <= '0;
    end else begin
      cur_q    <= cur_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: rtl/lockstep_cmp.sv
// Compares every copy against copy 0 each CHECK cycle and latches the first
// divergence; mismatch rises one cycle after the diverging cycle.
module lockstep_cmp
  import af_lockstep_pkg::*;
#(
  parameter int NUM_COPIES = 2,
  parameter int NUM_REQS   = DEF_NUM_REQS,
  parameter int WIDTH      = DEF_FIFO_DWIDTH,
  parameter int CNT_WID    = DEF_CNT_WID
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           check_en,
  input  logic [NUM_COPIES*NUM_REQS-1:0] pop,
  input  logic [NUM_COPIES*WIDTH-1:0]    data_out,
  input  logic [NUM_COPIES-1:0]          prop_signal,
  output logic                           mismatch,
  output logic [NUM_COPIES-1:0]          mismatch_mask,
  output logic [CNT_WID-1:0]             mismatch_cycle,
  output logic [CNT_WID-1:0]             cycle_cnt
);

  lk_state_e             state_q, state_d;
  logic [NUM_COPIES-1:0] diff, mask_q, mask_d;
  logic [CNT_WID-1:0]    cnt_q, cnt_d, mcyc_q, mcyc_d;

  // Data only matters when copy 0 actually granted something.
  always_comb begin
    diff = '0;
    for (int c = 1; c < NUM_COPIES; c++) begin
      diff[c] = (pop[c*NUM_REQS +: NUM_REQS] != pop[0 +: NUM_REQS])
             || ((|pop[0 +: NUM_REQS]) && (data_out[c*WIDTH +: WIDTH] != data_out[0 +: WIDTH]))
             || (prop_signal[c] != prop_signal[0]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    mcyc_d  = mcyc_q;
    case (state_q)
      IDLE: if (check_en) state_d = CHECK;
      CHECK: begin
        if (!check_en) begin
          state_d = IDLE;
        end else if (|diff) begin
          state_d = FAIL;
          mask_d  = diff;
          mcyc_d  = cnt_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WID'(1);
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      mcyc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      mcyc_q  <= mcyc_d;
    end
  end

  assign mismatch       = (state_q == FAIL);
  assign mismatch_mask  = mask_q;
  assign mismatch_cycle = mcyc_q;
  assign cycle_cnt      = cnt_q;

endmodule

// File: rtl/arbitrated_fifos_lockstep.sv
// NUM_COPIES duplicated arbitrated-FIFO systems, each with a scoreboard on
// FIFO_SEL, checked against copy 0 by a lockstep comparator.
module arbitrated_fifos_lockstep
  import af_lockstep_pkg::*;
#(
  parameter int NUM_COPIES = 2,
  parameter int NUM_REQS   = DEF_NUM_REQS,
  parameter int WIDTH      = DEF_FIFO_DWIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH,
  parameter int QWID       = DEF_ARB_QWID,
  parameter int FIFO_SEL   = 0,
  parameter int CNT_WID    = DEF_CNT_WID
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [NUM_REQS*QWID-1:0]             quantums,
  input  logic [NUM_COPIES*NUM_REQS-1:0]       push,
  input  logic [NUM_COPIES*NUM_REQS-1:0]       reqs,
  input  logic [NUM_COPIES*NUM_REQS*WIDTH-1:0] flat_data_in,
  input  logic                                 check_en,
  output logic [NUM_COPIES*NUM_REQS-1:0]       pop,
  output logic [NUM_COPIES*WIDTH-1:0]          data_out,
  output logic [NUM_COPIES-1:0]                prop_signal,
  output logic                                 mismatch,
  output logic [NUM_COPIES-1:0]                mismatch_mask,
  output logic [CNT_WID-1:0]                   mismatch_cycle,
  output logic [CNT_WID-1:0]                   cycle_cnt
);

  for (genvar c = 0; c < NUM_COPIES; c++) begin : g_copy
    arbitrated_fifos #(
      .NUM_REQS (NUM_REQS),
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .QWID     (QWID),
      .ABSTRACT (1'b1)
    ) u_af (
      .clk      (clk),
      .rst      (rst),
      .push     (push[req_lo(c, NUM_REQS) +: NUM_REQS]),
      .reqs     (reqs[req_lo(c, NUM_REQS) +: NUM_REQS]),
      .data_in  (flat_data_in[dat_lo(c, NUM_REQS, WIDTH) +: NUM_REQS*WIDTH]),
      .quantums (quantums),
      .pop      (pop[req_lo(c, NUM_REQS) +: NUM_REQS]),
      .data_out (data_out[c*WIDTH +: WIDTH])
    );

    SimpleScoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_sb (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .push        (push[req_lo(c, NUM_REQS) + FIFO_SEL]),
      .pop         (pop[req_lo(c, NUM_REQS) + FIFO_SEL]),
      .data_in     (flat_data_in[dat_lo(c, NUM_REQS, WIDTH) + FIFO_SEL*WIDTH +: WIDTH]),
      .data_out    (data_out[c*WIDTH +: WIDTH]),
      .prop_signal (prop_signal[c])
    );
  end

  lockstep_cmp #(
    .NUM_COPIES (NUM_COPIES),
    .NUM_REQS   (NUM_REQS),
    .WIDTH      (WIDTH),
    .CNT_WID    (CNT_WID)
  ) u_cmp (
    .clk            (clk),
    .rst            (rst),
    .check_en       (check_en),
    .pop            (pop),
    .data_out       (data_out),
    .prop_signal    (prop_signal),
    .mismatch       (mismatch),
    .mismatch_mask  (mismatch_mask),
    .mismatch_cycle (mismatch_cycle),
    .cycle_cnt      (cycle_cnt)
  );

endmodule

// File: tb/tb_arbitrated_fifos_lockstep.sv
// Directed bench: a 2-copy instance (16-bit counters) and a 3-copy instance
// (4-bit counters) driven one after the other.
module tb_arbitrated_fifos_lockstep;

  logic clk;
  int   n_total = 0;
  int   n_bad   = 0;

  // 2 copies, 2 reqs, 8-bit data, CNT_WID 16
  logic        a_rst, a_start, a_chk;
  logic [7:0]  a_quant;
  logic [3:0]  a_push, a_reqs, a_pop;
  logic [31:0] a_din;
  logic [15:0] a_dout, a_mcyc, a_cnt;
  logic [1:0]  a_prop, a_mask;
  logic        a_mm;

  // 3 copies, 2 reqs, 8-bit data, CNT_WID 4
  logic        b_rst, b_start, b_chk;
  logic [7:0]  b_quant;
  logic [5:0]  b_push, b_reqs, b_pop;
  logic [47:0] b_din;
  logic [23:0] b_dout;
  logic [2:0]  b_prop, b_mask;
  logic [3:0]  b_mcyc, b_cnt;
  logic        b_mm;

  logic        any_mm;

  arbitrated_fifos_lockstep #(
    .NUM_COPIES(2), .NUM_REQS(2), .WIDTH(8), .DEPTH(4), .QWID(4), .FIFO_SEL(0), .CNT_WID(16)
  ) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .quantums(a_quant), .push(a_push),
    .reqs(a_reqs), .flat_data_in(a_din), .check_en(a_chk), .pop(a_pop),
    .data_out(a_dout), .prop_signal(a_prop), .mismatch(a_mm), .mismatch_mask(a_mask),
    .mismatch_cycle(a_mcyc), .cycle_cnt(a_cnt)
  );

  arbitrated_fifos_lockstep #(
    .NUM_COPIES(3), .NUM_REQS(2), .WIDTH(8), .DEPTH(4), .QWID(4), .FIFO_SEL(0), .CNT_WID(4)
  ) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .quantums(b_quant), .push(b_push),
    .reqs(b_reqs), .flat_data_in(b_din), .check_en(b_chk), .pop(b_pop),
    .data_out(b_dout), .prop_signal(b_prop), .mismatch(b_mm), .mismatch_mask(b_mask),
    .mismatch_cycle(b_mcyc), .cycle_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_chk = 1'b0; a_quant = 8'h22;
    a_push = '0; a_reqs = '0; a_din = '0;
    b_rst = 1'b1; b_start = 1'b0; b_chk = 1'b0; b_quant = 8'h11;
    b_push = '0; b_reqs = '0; b_din = '0;

    // ---------------- reset state ----------------
    step(); step();
    check_eq("a_rst_mm",    a_mm, 0);
    check_eq("a_rst_mask",  a_mask, 0);
    check_eq("a_rst_mcyc",  a_mcyc, 0);
    check_eq("a_rst_cnt",   a_cnt, 0);
    check_eq("a_rst_state", dut_a.u_cmp.state_q, 0);
    check_eq("a_rst_prop",  a_prop, 2'b11);
    check_eq("a_rst_pop",   a_pop, 0);
    a_rst = 1'b0;

    // ---------------- clean run, 0x5 then 0xA ----------------
    a_chk = 1'b1; a_start = 1'b1; a_reqs = 4'b0101;
    step();  // entry cycle, not counted
    check_eq("a_entry_state", dut_a.u_cmp.state_q, 1);
    check_eq("a_entry_cnt",   a_cnt, 0);
    a_start = 1'b0; a_push = 4'b0101; a_din = {8'h00, 8'h05, 8'h00, 8'h05};
    step();  // cnt 1
    a_din = {8'h00, 8'h0A, 8'h00, 8'h0A};
    #1;
    check_eq("a_pop_5",  a_pop, 4'b0101);
    check_eq("a_dout_5", a_dout, 16'h0505);
    step();  // cnt 2
    a_push = 4'b0000;
    #1;
    check_eq("a_dout_A", a_dout, 16'h0A0A);
    step();  // cnt 3
    check_eq("a_cnt_3", a_cnt, 3);
    any_mm = 1'b0;
    for (int i = 0; i < 196; i++) begin
      step();
      any_mm = any_mm | a_mm;
    end
    check_eq("a_clean_mm",   any_mm, 0);
    check_eq("a_clean_cnt",  a_cnt, 199);
    check_eq("a_clean_prop", a_prop, 2'b11);

    // ---------------- divergence 0x5 vs 0x6 ----------------
    a_push = 4'b0101; a_din = {8'h00, 8'h06, 8'h00, 8'h05};
    step();  // cnt 200
    a_push = 4'b0000;
    #1;
    check_eq("a_div_pop",  a_pop, 4'b0101);
    check_eq("a_div_dout", a_dout, 16'h0605);
    check_eq("a_div_pre",  a_mm, 0);
    step();
    check_eq("a_div_mm",    a_mm, 1);
    check_eq("a_div_mask",  a_mask, 2'b10);
    check_eq("a_div_mcyc",  a_mcyc, 200);
    check_eq("a_div_cnt",   a_cnt, 200);
    check_eq("a_div_state", dut_a.u_cmp.state_q, 2);
    a_chk = 1'b0;
    step();
    check_eq("a_fail_hold_mm",    a_mm, 1);
    check_eq("a_fail_hold_state", dut_a.u_cmp.state_q, 2);

    // ---------------- rst from FAIL ----------------
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    check_eq("a_rst2_mm",    a_mm, 0);
    check_eq("a_rst2_mask",  a_mask, 0);
    check_eq("a_rst2_cnt",   a_cnt, 0);
    check_eq("a_rst2_mcyc",  a_mcyc, 0);
    check_eq("a_rst2_state", dut_a.u_cmp.state_q, 0);

    // ---------------- divergence with check_en low ----------------
    a_push = 4'b0101; a_din = {8'h00, 8'h06, 8'h00, 8'h05};
    step();
    a_push = 4'b0000;
    step();  // differing grant while IDLE
    check_eq("a_off_mm",  a_mm, 0);
    check_eq("a_off_cnt", a_cnt, 0);
    a_chk = 1'b1;
    step(); step(); step();  // entry + 2 counted
    check_eq("a_late_mm",  a_mm, 0);
    check_eq("a_late_cnt", a_cnt, 2);

    // ---------------- check_en drops with the diff ----------------
    a_push = 4'b0101; a_din = {8'h00, 8'h06, 8'h00, 8'h05};
    step();  // cnt 3
    a_push = 4'b0000; a_chk = 1'b0;
    step();
    check_eq("a_drop_mm",    a_mm, 0);
    check_eq("a_drop_mask",  a_mask, 0);
    check_eq("a_drop_cnt",   a_cnt, 3);
    check_eq("a_drop_state", dut_a.u_cmp.state_q, 0);

    // ---------------- 3 copies: counter saturation ----------------
    b_rst = 1'b0;
    check_eq("b_rst_cnt", b_cnt, 0);
    b_chk = 1'b1;
    step();
    for (int i = 0; i < 30; i++) step();
    check_eq("b_sat_cnt", b_cnt, 4'hF);
    step(); step(); step();
    check_eq("b_sat_hold", b_cnt, 4'hF);
    check_eq("b_sat_mm",   b_mm, 0);

    // ---------------- copy 2 reqs differ ----------------
    b_reqs = 6'b000101; b_push = 6'b010101;
    b_din = {8'h00, 8'h11, 8'h00, 8'h11, 8'h00, 8'h11};
    step();
    b_push = 6'b000000;
    #1;
    check_eq("b_req_pop", b_pop, 6'b000101);
    step();
    check_eq("b_req_mm",   b_mm, 1);
    check_eq("b_req_mask", b_mask, 3'b100);
    check_eq("b_req_mcyc", b_mcyc, 4'hF);

    // ---------------- copies 1 and 2 diverge together ----------------
    b_rst = 1'b1; b_chk = 1'b0;
    step();
    b_rst = 1'b0;
    check_eq("b_rst2_mm", b_mm, 0);
    b_reqs = 6'b010101; b_chk = 1'b1; b_push = 6'b010101;
    b_din = {8'h00, 8'h33, 8'h00, 8'h22, 8'h00, 8'h11};
    step();  // entry cycle
    b_push = 6'b000000;
    #1;
    check_eq("b_two_dout", b_dout, 24'h332211);
    step();
    check_eq("b_two_mm",   b_mm, 1);
    check_eq("b_two_mask", b_mask, 3'b110);
    check_eq("b_two_mcyc", b_mcyc, 0);
    check_eq("b_two_cnt",  b_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
